// File: rtl/teclado_ps2_if.sv
// teclado_ps2_if: PS/2 lines, receive enable and PicoBlaze handshake bundle
interface teclado_ps2_if;
   logic       ps2d;
   logic       ps2c;
   logic       rx_en;
   logic       new_data_pico;
   logic       new_data;
   logic [7:0] letra;
   modport slave (input ps2d, ps2c, rx_en, new_data_pico, output new_data, letra);
   modport master(output ps2d, ps2c, rx_en, new_data_pico, input new_data, letra);
endinterface

// File: rtl/teclado_ps2.sv
// teclado_ps2: PS/2 keyboard receiver reporting released-key scan codes to PicoBlaze
// Optional KEY_FILTER_EN: only F, H, T, arrow keys and ESC are reported.
module teclado_ps2 #(
   parameter int         FILTER_LEN = 8,
   parameter logic [7:0] BREAK_CODE = 8'hF0
) (
   input logic          clk,
   input logic          reset,
   teclado_ps2_if.slave kb
);
   typedef enum logic [1:0] {IDLE, DPS, LOAD} state_t;
   state_t                state_q, state_d;
   logic [FILTER_LEN-1:0] filt_q, filt_d;
   logic                  fps2c_q, fps2c_d;
   logic [3:0]            n_q, n_d;
   logic [10:1]           sr_q, sr_d;
   logic                  brk_q, brk_d;
   logic                  nd_q, nd_d;
   logic [7:0]            letra_q, letra_d;
   logic                  fall_edge, rx_done, keep;
   logic [7:0]            rx_byte;
   // frame bit 0 (start) shifts out of the low end, leaving the byte in sr_q[8:1]
   assign rx_byte = sr_q[8:1];
   assign rx_done = state_q == LOAD;
`ifdef KEY_FILTER_EN
   assign keep = rx_byte inside {8'h2B, 8'h33, 8'h2C, 8'h75, 8'h74, 8'h6B, 8'h72, 8'h76};
`else
   assign keep = 1'b1;
`endif
   always_comb begin
      filt_d    = {kb.ps2c, filt_q[FILTER_LEN-1:1]};
      fps2c_d   = &filt_q ? 1'b1 : ~|filt_q ? 1'b0 : fps2c_q;
      fall_edge = fps2c_q & ~fps2c_d;
      state_d   = state_q;
      n_d       = n_q;
      sr_d      = sr_q;
      case (state_q)
         IDLE: if (fall_edge && kb.rx_en) begin
            sr_d    = {kb.ps2d, sr_q[10:2]};
            n_d     = 4'd9;
            state_d = DPS;
         end
         DPS: if (fall_edge) begin
            sr_d    = {kb.ps2d, sr_q[10:2]};
            n_d     = n_q == 4'd0 ? n_q : n_q - 4'd1;
            state_d = n_q == 4'd0 ? LOAD : DPS;
         end
         default: state_d = IDLE;
      endcase
      brk_d   = brk_q;
      letra_d = letra_q;
      // a decoded code below overrides a same-cycle acknowledge
      nd_d    = nd_q & ~kb.new_data_pico;
      if (rx_done) begin
         if (rx_byte == BREAK_CODE) brk_d = 1'b1;
         else if (brk_q) begin
            brk_d = 1'b0;
            if (keep) begin
               letra_d = rx_byte;
               nd_d    = 1'b1;
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         filt_q  <= '1;
         fps2c_q <= 1'b1;
         state_q <= IDLE;
         n_q     <= '0;
         sr_q    <= '0;
         brk_q   <= 1'b0;
         letra_q <= 8'h00;
         nd_q    <= 1'b0;
      end else begin
         filt_q  <= filt_d;
         fps2c_q <= fps2c_d;
         state_q <= state_d;
         n_q     <= n_d;
         sr_q    <= sr_d;
         brk_q   <= brk_d;
         letra_q <= letra_d;
         nd_q    <= nd_d;
      end
   end
   assign kb.new_data = nd_q;
   assign kb.letra    = letra_q;
endmodule

// File: tb/tb_teclado_ps2.sv
// tb_teclado_ps2: directed PS/2 frames with a vector table and hand-written corner sequences
module tb_teclado_ps2;
   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_fail = 0;
   teclado_ps2_if kb();
   teclado_ps2 dut (.clk(clk), .reset(rst), .kb(kb));
   always #5 clk = ~clk;
   typedef struct {
      logic       ack;
      logic [7:0] code;
      logic [7:0] letra;
      logic       nd;
   } vec_t;
   vec_t v[16];
   task automatic chk(input string nm, input logic [7:0] el, input logic en);
      n_chk += 2;
      if (kb.letra !== el) begin
         n_fail++;
         $display("FAIL %s letra: got %h want %h", nm, kb.letra, el);
      end
      if (kb.new_data !== en) begin
         n_fail++;
         $display("FAIL %s new_data: got %b want %b", nm, kb.new_data, en);
      end
   endtask
   task automatic ack_pulse();
      kb.new_data_pico = 1'b1;
      @(negedge clk);
      kb.new_data_pico = 1'b0;
   endtask
   // mode 1: check decode latency on the stop bit; mode 2: acknowledge in the decode cycle
   task automatic send(input logic [7:0] b, input int nbits, input int mode);
      logic [10:0] f;
      f = {1'b1, ~^b, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         kb.ps2d = f[i];
         repeat (25) @(negedge clk);
         kb.ps2c = 1'b0;
         for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (i == 10 && mode == 1 && k == 8) chk("lat_early", 8'h00, 1'b0);
            if (i == 10 && mode == 1 && k == 10) chk("lat_2clk", 8'h2B, 1'b1);
            if (i == 10 && mode == 2 && k == 9) kb.new_data_pico = 1'b1;
            if (i == 10 && mode == 2 && k == 10) kb.new_data_pico = 1'b0;
         end
         kb.ps2c = 1'b1;
         repeat (25) @(negedge clk);
      end
   endtask
   initial begin
      v[0]  = '{1'b0, 8'hF0, 8'h2B, 1'b1};
      v[1]  = '{1'b0, 8'h33, 8'h33, 1'b1};
      v[2]  = '{1'b0, 8'hF0, 8'h33, 1'b1};
      v[3]  = '{1'b0, 8'h2C, 8'h2C, 1'b1};
      v[4]  = '{1'b0, 8'hF0, 8'h2C, 1'b1};
      v[5]  = '{1'b0, 8'h75, 8'h75, 1'b1};
      v[6]  = '{1'b0, 8'hF0, 8'h75, 1'b1};
      v[7]  = '{1'b0, 8'h74, 8'h74, 1'b1};
      v[8]  = '{1'b0, 8'hF0, 8'h74, 1'b1};
      v[9]  = '{1'b0, 8'h6B, 8'h6B, 1'b1};
      v[10] = '{1'b0, 8'hF0, 8'h6B, 1'b1};
      v[11] = '{1'b0, 8'h72, 8'h72, 1'b1};
      v[12] = '{1'b0, 8'hF0, 8'h72, 1'b1};
      v[13] = '{1'b0, 8'h76, 8'h76, 1'b1};
      v[14] = '{1'b0, 8'h1C, 8'h76, 1'b1};
      v[15] = '{1'b1, 8'h1C, 8'h76, 1'b0};
      kb.ps2d = 1'b1;
      kb.ps2c = 1'b1;
      kb.rx_en = 1'b0;
      kb.new_data_pico = 1'b0;
      rst = 1'b1;
      repeat (10) @(negedge clk);
      chk("reset", 8'h00, 1'b0);
      rst = 1'b0;
      send(8'hF0, 11, 0);
      send(8'h2B, 11, 0);
      chk("rx_en_low", 8'h00, 1'b0);
      kb.rx_en = 1'b1;
      send(8'hF0, 11, 0);
      chk("break_only", 8'h00, 1'b0);
      send(8'h2B, 11, 1);
      chk("first_key", 8'h2B, 1'b1);
      for (int i = 0; i < 16; i++) begin
         if (v[i].ack) ack_pulse();
         send(v[i].code, 11, 0);
         chk($sformatf("vec%0d", i), v[i].letra, v[i].nd);
      end
      send(8'hF0, 11, 0);
      chk("f0_after_ack", 8'h76, 1'b0);
      send(8'h1C, 11, 0);
`ifdef KEY_FILTER_EN
      chk("release_1c", 8'h76, 1'b0);
`else
      chk("release_1c", 8'h1C, 1'b1);
`endif
      send(8'hF0, 11, 0);
      send(8'hF0, 11, 0);
      send(8'h2B, 11, 0);
      chk("double_f0", 8'h2B, 1'b1);
      ack_pulse();
      chk("ack_clears", 8'h2B, 1'b0);
      send(8'hF0, 11, 0);
      send(8'h33, 11, 2);
      chk("ack_same_clk", 8'h33, 1'b1);
      send(8'hF0, 11, 0);
      send(8'h2C, 5, 0);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      chk("mid_reset", 8'h00, 1'b0);
      send(8'h2B, 11, 0);
      chk("brk_cleared", 8'h00, 1'b0);
      send(8'hF0, 11, 0);
      send(8'h2B, 11, 0);
      chk("after_reset", 8'h2B, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
